// File: rtl/lc3b_types.sv
// Shared LC-3b types for the fetch unit: word type, fetch FSM encoding, reset PC
// and the IF/ID payload.
package lc3b_types;

  localparam int unsigned LC3B_WORD_W = 16;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;

  localparam lc3b_word LC3B_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } lc3b_fetch_state;

  // Instruction presented to the IF/ID barrier.
  typedef struct packed {
    lc3b_word ir;
    lc3b_word pc;
    lc3b_word pc_plus2;
  } lc3b_if_payload;

endpackage

// File: rtl/fetch_unit_plus2.sv
// plus2: 16-bit word increment by two, wrapping modulo 2^16.
module plus2
  import lc3b_types::*;
(
  input  lc3b_word a,
  output lc3b_word sum_c
);

  assign sum_c = lc3b_word'(a + lc3b_word'(2));

endmodule

// File: rtl/fetch_unit.sv
// LC-3b instruction fetch unit: one fetch in flight, redirect/kill, IF/ID hold.
// Build option: LC3B_IF_BACK2BACK_EN lets a HOLD transfer start the next fetch directly.
module fetch_unit
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  lc3b_word pc_next,
  input  logic     pc_load,
  input  logic     stage_IF_stall,
  output logic     imem_read,
  output lc3b_word imem_address,
  input  logic     imem_resp,
  input  lc3b_word imem_rdata,
  output logic     if_valid,
  output lc3b_word if_ir,
  output lc3b_word if_pc,
  output lc3b_word if_pc_plus2,
  input  logic     id_ready
);

  lc3b_fetch_state state, next_state;

  lc3b_word       pc, pc_d;
  lc3b_word       fetch_addr, fetch_addr_d;
  lc3b_word       fetch_addr_plus2;
  lc3b_if_payload payload_q, payload_d;
  logic           if_valid_q, if_valid_d;
  logic           imem_read_q, imem_read_d;

  plus2 u_fetch_plus2 (
    .a     (fetch_addr),
    .sum_c (fetch_addr_plus2)
  );

  // State and datapath registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= LC3B_RESET_PC;
      fetch_addr  <= '0;
      payload_q   <= '0;
      if_valid_q  <= 1'b0;
      imem_read_q <= 1'b0;
    end else begin
      state       <= next_state;
      pc          <= pc_d;
      fetch_addr  <= fetch_addr_d;
      payload_q   <= payload_d;
      if_valid_q  <= if_valid_d;
      imem_read_q <= imem_read_d;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    next_state   = state;
    pc_d         = pc;
    fetch_addr_d = fetch_addr;
    payload_d    = payload_q;

    case (state)
      IDLE: begin
        if (pc_load) begin
          pc_d = pc_next;
        end else if (!stage_IF_stall) begin
          fetch_addr_d = pc;
          next_state   = REQ;
        end
      end

      REQ: begin
        if (pc_load) begin
          pc_d       = pc_next;
          next_state = imem_resp ? IDLE : DRAIN;
        end else if (imem_resp) begin
          payload_d.ir       = imem_rdata;
          payload_d.pc       = fetch_addr;
          payload_d.pc_plus2 = fetch_addr_plus2;
          pc_d               = fetch_addr_plus2;
          next_state         = HOLD;
        end
      end

      // A killed fetch is still owed a response; swallow it here.
      DRAIN: begin
        if (pc_load) begin
          pc_d = pc_next;
        end
        if (imem_resp) begin
          next_state = IDLE;
        end
      end

      HOLD: begin
        if (pc_load) begin
          pc_d       = pc_next;
          payload_d  = '0;
          next_state = IDLE;
        end else if (id_ready) begin
          payload_d = '0;
`ifdef LC3B_IF_BACK2BACK_EN
          if (!stage_IF_stall) begin
            fetch_addr_d = pc;
            next_state   = REQ;
          end else begin
            next_state = IDLE;
          end
`else
          next_state = IDLE;
`endif
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase

    if_valid_d  = (next_state == HOLD);
    imem_read_d = (next_state == REQ) || (next_state == DRAIN);
  end

  // Payload is cleared on leaving HOLD, so the IF/ID outputs read zero elsewhere.
  assign imem_read    = imem_read_q;
  assign imem_address = fetch_addr;
  assign if_valid     = if_valid_q;
  assign if_ir        = payload_q.ir;
  assign if_pc        = payload_q.pc;
  assign if_pc_plus2  = payload_q.pc_plus2;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit; memory responses are driven by the steps.
module tb_fetch_unit;
  import lc3b_types::*;

  logic     clk;
  logic     rst_n;
  lc3b_word pc_next;
  logic     pc_load;
  logic     stage_IF_stall;
  logic     imem_read;
  lc3b_word imem_address;
  logic     imem_resp;
  lc3b_word imem_rdata;
  logic     if_valid;
  lc3b_word if_ir;
  lc3b_word if_pc;
  lc3b_word if_pc_plus2;
  logic     id_ready;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  lc3b_if_payload exp_q[$];

`ifdef LC3B_IF_BACK2BACK_EN
  localparam int EXP_PERIOD = 3;
`else
  localparam int EXP_PERIOD = 4;
`endif

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_next        (pc_next),
    .pc_load        (pc_load),
    .stage_IF_stall (stage_IF_stall),
    .imem_read      (imem_read),
    .imem_address   (imem_address),
    .imem_resp      (imem_resp),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ir          (if_ir),
    .if_pc          (if_pc),
    .if_pc_plus2    (if_pc_plus2),
    .id_ready       (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"}, 16'(imem_read), 16'd0);
    chk({tag, "_addr"}, imem_address, 16'd0);
    chk({tag, "_valid"}, 16'(if_valid), 16'd0);
    chk({tag, "_ir"}, if_ir, 16'd0);
    chk({tag, "_pc"}, if_pc, 16'd0);
    chk({tag, "_pc2"}, if_pc_plus2, 16'd0);
  endtask

  // Advance until a read request is seen (first REQ cycle), bounded.
  task automatic wait_read(input string tag, input lc3b_word exp_addr);
    int n;
    n = 0;
    while (imem_read !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_read_seen"}, 16'(imem_read), 16'd1);
    chk({tag, "_addr"}, imem_address, exp_addr);
  endtask

  // Called in the first REQ cycle: respond in the second REQ cycle.
  task automatic respond(input string tag, input lc3b_word data);
    lc3b_if_payload e;
    tick();
    chk({tag, "_read_held"}, 16'(imem_read), 16'd1);
    e.ir       = data;
    e.pc       = imem_address;
    e.pc_plus2 = lc3b_word'(imem_address + 16'd2);
    exp_q.push_back(e);
    imem_resp  = 1'b1;
    imem_rdata = data;
    tick();
    imem_resp  = 1'b0;
    imem_rdata = '0;
  endtask

  task automatic check_out(input string tag);
    lc3b_if_payload e;
    chk({tag, "_valid"}, 16'(if_valid), 16'd1);
    chk({tag, "_sb_nonempty"}, 16'(exp_q.size() != 0), 16'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_ir"}, if_ir, e.ir);
      chk({tag, "_pc"}, if_pc, e.pc);
      chk({tag, "_pc2"}, if_pc_plus2, e.pc_plus2);
    end
  endtask

  initial begin
    int t_start[4];

    rst_n          = 1'b0;
    pc_next        = '0;
    pc_load        = 1'b0;
    stage_IF_stall = 1'b0;
    imem_resp      = 1'b0;
    imem_rdata     = '0;
    id_ready       = 1'b1;

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");

    // Basic fetch
    rst_n = 1'b1;
    wait_read("basic", 16'h0000);
    respond("basic", 16'h1234);
    check_out("basic_out");
    wait_read("basic_next", 16'h0002);

    // Redirect during REQ, response discarded in DRAIN
    pc_load = 1'b1;
    pc_next = 16'h3000;
    tick();
    pc_load = 1'b0;
    chk("drain_read", 16'(imem_read), 16'd1);
    imem_resp  = 1'b1;
    imem_rdata = 16'hBEEF;
    tick();
    imem_resp  = 1'b0;
    imem_rdata = '0;
    chk("drain_valid", 16'(if_valid), 16'd0);
    chk("drain_ir", if_ir, 16'd0);
    wait_read("redirect", 16'h3000);

    // Two redirects while draining: last one wins
    pc_load = 1'b1;
    pc_next = 16'h4000;
    tick();
    pc_next = 16'h5000;
    tick();
    pc_load   = 1'b0;
    imem_resp = 1'b1;
    tick();
    imem_resp = 1'b0;
    chk("drain2_valid", 16'(if_valid), 16'd0);
    wait_read("last_wins", 16'h5000);

    // Redirect with response in the same REQ cycle
    pc_load    = 1'b1;
    pc_next    = 16'h6000;
    imem_resp  = 1'b1;
    imem_rdata = 16'hDEAD;
    tick();
    pc_load    = 1'b0;
    imem_resp  = 1'b0;
    imem_rdata = '0;
    chk("simreq_valid", 16'(if_valid), 16'd0);
    chk("simreq_read", 16'(imem_read), 16'd0);
    wait_read("simreq", 16'h6000);

    // Redirect in HOLD beats id_ready
    respond("hold", 16'hA5A5);
    check_out("hold_out");
    pc_load = 1'b1;
    pc_next = 16'h7000;
    tick();
    pc_load = 1'b0;
    chk("holdredir_valid", 16'(if_valid), 16'd0);
    chk("holdredir_ir", if_ir, 16'd0);
    wait_read("holdredir", 16'h7000);

    // Stall: ignored in REQ, holds HOLD, blocks IDLE
    id_ready       = 1'b0;
    stage_IF_stall = 1'b1;
    respond("stall", 16'hC0DE);
    check_out("stall_out");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_valid", 16'(if_valid), 16'd1);
      chk("stall_hold_ir", if_ir, 16'hC0DE);
    end
    id_ready = 1'b1;
    tick();
    chk("stall_xfer_valid", 16'(if_valid), 16'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_idle_read", 16'(imem_read), 16'd0);
    end
    stage_IF_stall = 1'b0;
    wait_read("stall_resume", 16'h7002);

    // PC wrap at 16'hFFFE
    pc_load = 1'b1;
    pc_next = 16'hFFFE;
    tick();
    pc_load   = 1'b0;
    imem_resp = 1'b1;
    tick();
    imem_resp = 1'b0;
    wait_read("wrap", 16'hFFFE);
    respond("wrap", 16'h1111);
    check_out("wrap_out");
    wait_read("wrap_next", 16'h0000);
    respond("wrap2", 16'h2222);
    check_out("wrap2_out");
    wait_read("wrap2_next", 16'h0002);

    // Reset mid-REQ overrides redirect and response
    rst_n      = 1'b0;
    pc_load    = 1'b1;
    pc_next    = 16'h4444;
    imem_resp  = 1'b1;
    imem_rdata = 16'h9999;
    tick();
    chk_all_zero("rst_midreq");
    // Late response in IDLE is ignored
    rst_n          = 1'b1;
    pc_load        = 1'b0;
    stage_IF_stall = 1'b1;
    imem_rdata     = 16'h7777;
    tick();
    chk("late_valid", 16'(if_valid), 16'd0);
    chk("late_read", 16'(imem_read), 16'd0);
    imem_resp      = 1'b0;
    imem_rdata     = '0;
    stage_IF_stall = 1'b0;

    // Throughput with continuous id_ready
    for (int i = 0; i < 4; i++) begin
      wait_read("tput", lc3b_word'(16'(2 * i)));
      t_start[i] = cyc;
      respond("tput", lc3b_word'(16'h5000 + 16'(i)));
      check_out("tput_out");
    end
    for (int i = 1; i < 4; i++) begin
      chk("tput_period", 16'(t_start[i] - t_start[i-1]), 16'(EXP_PERIOD));
    end

    chk("sb_empty", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The port list SHALL be, clock and reset first: clk  in  1  sole clock, all state updates on its rising edge.
REQ-002 rst_n  in  1  reset, synchronous and active-low.
REQ-003 pc_next  in  16  redirect target (lc3b_word), taken from the branch controller PC output.
REQ-004 pc_load  in  1  redirect strobe: load pc_next and kill any fetch in flight.
REQ-005 stage_IF_stall  in  1  pipeline-control stall; blocks the start of a new fetch only.
REQ-006 imem_read  out  1  instruction-memory read request.
REQ-007 imem_address  out  16  address of the fetch in flight.
REQ-008 imem_resp  in  1  one-cycle read completion.
REQ-009 imem_rdata  in  16  instruction word, valid with imem_resp.
REQ-010 if_valid  out  1  instruction presented to the IF/ID barrier.
REQ-011 if_ir, if_pc, if_pc_plus2  out  16 each  instruction, its address, and its address + 2.
REQ-012 id_ready  in  1  IF/ID barrier accepts; a transfer occurs when if_valid & id_ready.

Function
REQ-013 State machine SHALL have exactly four states: IDLE, REQ, DRAIN, HOLD.
REQ-014 Registers SHALL be pc (next fetch address), fetch_addr, ir_q, pc_q.
REQ-015 imem_read SHALL be 1 in REQ and DRAIN only, and imem_address SHALL equal fetch_addr; once raised, imem_read SHALL stay high until imem_resp.
REQ-016 IDLE: pc_load -> pc<=pc_next, stay IDLE; else ~stage_IF_stall -> fetch_addr<=pc, go to REQ; else stay.
REQ-017 REQ, no pc_load: imem_resp -> ir_q<=imem_rdata, pc_q<=fetch_addr, pc<=fetch_addr+2 (mod 2^16), go to HOLD.
REQ-018 REQ, pc_load with imem_resp in the same cycle: pc<=pc_next, discard data, go to IDLE.
REQ-019 REQ, pc_load without imem_resp: pc<=pc_next, go to DRAIN.
REQ-020 DRAIN: on imem_resp, discard data and go to IDLE; a pc_load in DRAIN SHALL overwrite pc (last one wins).
REQ-021 HOLD: if_valid=1, with if_ir=ir_q, if_pc=pc_q, if_pc_plus2=pc_q+2.
REQ-022 In HOLD, pc_load has priority: pc<=pc_next, if_valid drops next cycle, go to IDLE, even when id_ready=1 (no transfer counted).
REQ-023 In HOLD, id_ready & ~pc_load -> transfer, leave HOLD per REQ-032/033.
REQ-024 In HOLD, stage_IF_stall SHALL NOT clear if_valid; the instruction is held until transfer or redirect.
REQ-025 Fetch latency SHALL be: REQ entered one cycle after the IDLE decision, if_valid high the cycle after imem_resp.
REQ-026 if_valid, if_ir, if_pc and if_pc_plus2 SHALL be 0 outside HOLD; no output depends combinationally on imem_rdata.
REQ-027 PC arithmetic SHALL be 16-bit unsigned and wrap: fetch at 16'hFFFE yields pc=16'h0000.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, pc=16'h0000, fetch_addr=ir_q=pc_q=0; all outputs read 0 the following cycle.
REQ-029 Reset mid-REQ or mid-DRAIN SHALL drop imem_read the next cycle; a late imem_resp in IDLE SHALL be ignored.
REQ-030 Reset SHALL override pc_load and all other inputs.

Configuration
REQ-031 Macro LC3B_IF_BACK2BACK_EN SHALL select the HOLD exit path.
REQ-032 Defined: a transfer with ~stage_IF_stall SHALL set fetch_addr<=pc and go directly to REQ (no IDLE bubble); a transfer with stage_IF_stall goes to IDLE.
REQ-033 Undefined: every transfer SHALL go to IDLE; the minimum fetch-to-fetch spacing is one cycle longer.

Structure
REQ-034 lc3b_word and a new enum lc3b_fetch_state (IDLE, REQ, DRAIN, HOLD) SHALL live in package lc3b_types; reset PC 16'h0000 SHALL be package constant LC3B_RESET_PC.
REQ-035 The +2 adders SHALL be instances of the existing plus2 sub-module; no other sub-module.

Verification
REQ-036 Basic fetch: reset, then imem_resp=1 with rdata=16'h1234 on the second REQ cycle, id_ready=1 -> if_valid with if_ir=16'h1234, if_pc=0, if_pc_plus2=2; the next imem_address is 16'h0002.
REQ-037 Redirect during REQ: pc_load=1 with pc_next=16'h3000 and no resp -> DRAIN; the resp with 16'hBEEF is discarded (if_valid stays 0); the next fetch address is 16'h3000.
REQ-038 Simultaneous events: pc_load with imem_resp in REQ -> data discarded, IDLE, pc=pc_next; in HOLD with id_ready=1 -> no transfer, if_valid=0 next cycle.
REQ-039 Stall: stage_IF_stall=1 in IDLE for 5 cycles -> imem_read=0 throughout; stall raised in REQ -> imem_read held until resp; stall in HOLD -> if_valid held.
REQ-040 Wrap and reset: pc_next=16'hFFFE fetch -> next address 16'h0000; rst_n=0 mid-REQ -> imem_read=0 and all outputs 0 the next cycle.
REQ-041 Configuration: run the continuous id_ready=1, 1-cycle-memory throughput test with and without LC3B_IF_BACK2BACK_EN -> fetch starts every 3 vs 4 cycles.
